// File: rtl/gcd_pkg.sv
// gcd_pkg: shared width, default timing constants and initiator state encoding for the GCD slice
package gcd_pkg;
  localparam int GCD_WIDTH = 16;
  localparam int GCD_REQ_HOLD = 2;
  localparam int GCD_TIMEOUT = 1024;
  typedef enum logic [1:0] {IDLE, A_REQ, A_WAIT, B_REQ} gcd_state_e;
endpackage

// File: rtl/gcd_initiator.sv
// gcd_initiator: sequences an operand pair onto the GCD unit's req/ack bus and buffers the result
module gcd_initiator
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int REQ_HOLD = GCD_REQ_HOLD,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_timeout,
  output logic             gcd_req,
  output logic [WIDTH-1:0] gcd_AB,
  input  logic             gcd_ack,
  input  logic [WIDTH-1:0] gcd_C
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int HW = $clog2(REQ_HOLD + 1);
  localparam int CW = TW > HW ? TW : HW;
  localparam logic [CW-1:0] HOLD_LAST = CW'(REQ_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  gcd_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d, ab_q, ab_d, c_q, c_d;
  logic req_q, req_d, valid_q, valid_d, to_q, to_d;
  logic accept, bypass, expired;
  assign in_ready = !reset && state_q == IDLE && (!valid_q || out_ready);
  assign accept = in_ready && in_valid;
  assign bypass = in_a == '0 || in_b == '0;
  assign expired = TIMEOUT != 0 && cnt_q == TO_LAST;
  assign out_valid = valid_q;
  assign out_c = c_q;
  assign out_timeout = to_q;
  assign gcd_req = req_q;
  assign gcd_AB = ab_q;
  // one counter serves both the A-phase hold and the ack watchdog
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    b_d = b_q;
    ab_d = ab_q;
    req_d = req_q;
    valid_d = valid_q && !out_ready;
    c_d = c_q;
    to_d = to_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (accept && bypass) begin
        valid_d = 1'b1;
        c_d = in_a | in_b;
        to_d = 1'b0;
      end else if (accept) begin
        state_d = A_REQ;
        req_d = 1'b1;
        ab_d = in_a;
        b_d = in_b;
      end
    end else if (state_q == A_REQ) begin
      if (cnt_q == HOLD_LAST) begin
        state_d = A_WAIT;
        req_d = 1'b0;
        cnt_d = '0;
      end
    end else if (gcd_ack) begin
      cnt_d = '0;
      state_d = state_q == A_WAIT ? B_REQ : IDLE;
      req_d = state_q == A_WAIT;
      ab_d = state_q == A_WAIT ? b_q : '0;
      if (state_q == B_REQ) begin
        valid_d = 1'b1;
        c_d = gcd_C;
        to_d = 1'b0;
      end
    end else if (expired) begin
      state_d = IDLE;
      cnt_d = '0;
      req_d = 1'b0;
      ab_d = '0;
      valid_d = 1'b1;
      c_d = '0;
      to_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      b_q <= '0;
      ab_q <= '0;
      req_q <= 1'b0;
      valid_q <= 1'b0;
      c_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      b_q <= b_d;
      ab_q <= ab_d;
      req_q <= req_d;
      valid_q <= valid_d;
      c_q <= c_d;
      to_q <= to_d;
    end
  end
endmodule
